scmips_datapath: RTL and testbench

//  Single-cycle MIPS datapath behind the fetch stage: decode/register file (ID), ALU and next-PC logic (EX),

---
 rtl/scmips_pkg.sv | 45 ++++
 rtl/scmips_regfile.sv | 36 +++
 rtl/scmips_datapath.sv | 156 +++++++++++++++
 tb/tb_scmips_datapath.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/scmips_pkg.sv
// rtl/scmips_pkg.sv - shared opcode/funct constants and enums for the single-cycle MIPS datapath
package scmips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_LINK
  } wb_sel_t;

endpackage

// File: rtl/scmips_regfile.sv
// rtl/scmips_regfile.sv - 32x32 register file, two async read ports, one sync write port
// Purpose: MIPS general register file; R0 reads 0 and ignores writes.
// Ports:
//   clk            clock, write and clear on rising edge
//   rst            synchronous active-low clear of all registers
//   raddr1/raddr2  read addresses; rdata1/rdata2 combinational read data
//   we/waddr/wdata write enable, address and data
module scmips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // R0 is forced to zero on read so its storage never matters.
  assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : regs[raddr2];

endmodule

// File: rtl/scmips_datapath.sv
// rtl/scmips_datapath.sv - single-cycle MIPS datapath: decode, regfile, ALU, next-PC, data memory, write-back
// Purpose: executes one fetched instruction per clock; state commits on the rising edge.
// Ports:
//   CLK     clock
//   RST     synchronous active-low reset (clears registers, blocks writes, forces newPC to 0)
//   nextPC  PC+4 of the current instruction
//   Ins     current instruction word
//   newPC   PC the fetch unit loads at the next edge
//   Result  ALU result
//   Wdata   register write-back data
module scmips_datapath
  import scmips_pkg::*;
#(
  parameter int DM_WORDS = 256,
  parameter int DM_AW    = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] nextPC,
  input  logic [31:0] Ins,
  output logic [31:0] newPC,
  output logic [31:0] Result,
  output logic [31:0] Wdata
);

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm;
  logic [25:0] tgt;

  assign op  = Ins[31:26];
  assign rs  = Ins[25:21];
  assign rt  = Ins[20:16];
  assign rd  = Ins[15:11];
  assign sh  = Ins[10:6];
  assign fn  = Ins[5:0];
  assign imm = Ins[15:0];
  assign tgt = Ins[25:0];

  alu_op_t     alu_op;
  wb_sel_t     wb_sel;
  logic        use_imm, zero_ext, reg_we, mem_we;
  logic        is_beq, is_bne, is_jmp, is_jr;
  logic [4:0]  dst;

  always_comb begin
    alu_op   = ALU_NONE;
    wb_sel   = WB_ALU;
    use_imm  = 1'b0;
    zero_ext = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_jmp   = 1'b0;
    is_jr    = 1'b0;
    dst      = rt;
    unique case (op)
      OP_RTYPE: begin
        dst = rd;
        unique case (fn)
          FN_ADD:  begin alu_op = ALU_ADD; reg_we = 1'b1; end
          FN_SUB:  begin alu_op = ALU_SUB; reg_we = 1'b1; end
          FN_AND:  begin alu_op = ALU_AND; reg_we = 1'b1; end
          FN_OR:   begin alu_op = ALU_OR;  reg_we = 1'b1; end
          FN_SLT:  begin alu_op = ALU_SLT; reg_we = 1'b1; end
          FN_SLL:  begin alu_op = ALU_SLL; reg_we = 1'b1; end
          FN_SRL:  begin alu_op = ALU_SRL; reg_we = 1'b1; end
          FN_JR:   is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin alu_op = ALU_ADD; use_imm = 1'b1; reg_we = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; use_imm = 1'b1; zero_ext = 1'b1; reg_we = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  use_imm = 1'b1; zero_ext = 1'b1; reg_we = 1'b1; end
      OP_LUI:  begin alu_op = ALU_LUI; reg_we = 1'b1; end
      OP_LW:   begin alu_op = ALU_ADD; use_imm = 1'b1; reg_we = 1'b1; wb_sel = WB_MEM; end
      OP_SW:   begin alu_op = ALU_ADD; use_imm = 1'b1; mem_we = 1'b1; end
      OP_BEQ:  begin alu_op = ALU_SUB; is_beq = 1'b1; end
      OP_BNE:  begin alu_op = ALU_SUB; is_bne = 1'b1; end
      OP_J:    is_jmp = 1'b1;
      OP_JAL:  begin is_jmp = 1'b1; reg_we = 1'b1; dst = REG_RA; wb_sel = WB_LINK; end
      default: ;
    endcase
  end

  logic [31:0] rdata1, rdata2, ed32, alu_b;

  assign ed32  = zero_ext ? {16'h0, imm} : {{16{imm[15]}}, imm};
  assign alu_b = use_imm ? ed32 : rdata2;

  always_comb begin
    Result = 32'h0;
    unique case (alu_op)
      ALU_ADD: Result = rdata1 + alu_b;
      ALU_SUB: Result = rdata1 - alu_b;
      ALU_AND: Result = rdata1 & alu_b;
      ALU_OR:  Result = rdata1 | alu_b;
      ALU_SLT: Result = {31'h0, $signed(rdata1) < $signed(alu_b)};
      ALU_SLL: Result = rdata2 << sh;
      ALU_SRL: Result = rdata2 >> sh;
      ALU_LUI: Result = {imm, 16'h0};
      default: Result = 32'h0;
    endcase
  end

  // Data memory: byte address wraps onto DM_WORDS words; not cleared by reset.
  logic [31:0]      dmem [DM_WORDS];
  logic [DM_AW-1:0] dm_idx;
  logic [31:0]      mem_rdata;

  assign dm_idx    = Result[DM_AW+1:2];
  assign mem_rdata = dmem[dm_idx];

  always_ff @(posedge CLK) begin
    if (RST && mem_we) begin
      dmem[dm_idx] <= rdata2;
    end
  end

  always_comb begin
    Wdata = Result;
    unique case (wb_sel)
      WB_MEM:  Wdata = mem_rdata;
      WB_LINK: Wdata = nextPC;
      default: Wdata = Result;
    endcase
  end

  scmips_regfile u_regfile (
    .clk    (CLK),
    .rst    (RST),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (reg_we && RST),
    .waddr  (dst),
    .wdata  (Wdata)
  );

  logic        taken;
  logic [31:0] pc_sel;

  assign taken = (is_beq && (rdata1 == rdata2)) || (is_bne && (rdata1 != rdata2));

  always_comb begin
    pc_sel = nextPC;
    if (taken)       pc_sel = nextPC + (ed32 << 2);
    else if (is_jmp) pc_sel = {nextPC[31:28], tgt, 2'b00};
    else if (is_jr)  pc_sel = rdata1;
  end

  assign newPC = RST ? pc_sel : 32'h0;

endmodule

// File: tb/tb_scmips_datapath.sv
// tb/tb_scmips_datapath.sv - directed self-checking bench for scmips_datapath
module tb_scmips_datapath;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] nextPC = 32'h0;
  logic [31:0] Ins = 32'h0;
  logic [31:0] newPC, Result, Wdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  scmips_datapath dut (
    .CLK    (CLK),
    .RST    (RST),
    .nextPC (nextPC),
    .Ins    (Ins),
    .newPC  (newPC),
    .Result (Result),
    .Wdata  (Wdata)
  );

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                         input int sh, input logic [5:0] fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Drive one instruction on the falling edge; outputs settle before the next rising edge commits it.
  task automatic apply(input logic rst, input logic [31:0] ins, input logic [31:0] npc);
    @(negedge CLK);
    RST = rst;
    Ins = ins;
    nextPC = npc;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read a register back through add $0,$r,$0 (write to R0 is discarded).
  task automatic read_reg(input string tag, input int r, input logic [31:0] exp);
    apply(1'b1, rtype(r, 0, 0, 0, 6'h20), 32'h0000_1000);
    check(tag, Result, exp);
  endtask

  initial begin
    // Reset
    apply(1'b0, 32'h0, 32'h0000_0104);
    check("rst_newpc_a", newPC, 32'h0);
    apply(1'b0, jtype(6'h02, 26'h40), 32'h0000_0104);
    check("rst_newpc_b", newPC, 32'h0);
    for (int r = 0; r < 32; r++) begin
      read_reg($sformatf("rst_r%0d", r), r, 32'h0);
    end
    check("post_rst_newpc", newPC, 32'h0000_1000);

    // ori / addi / add
    apply(1'b1, itype(6'h0D, 0, 1, 16'h00F0), 32'h4);
    check("ori_result", Result, 32'h0000_00F0);
    apply(1'b1, itype(6'h08, 0, 2, 16'hFFFF), 32'h8);
    check("addi_wdata", Wdata, 32'hFFFF_FFFF);
    read_reg("r1", 1, 32'h0000_00F0);
    read_reg("r2", 2, 32'hFFFF_FFFF);
    apply(1'b1, rtype(1, 2, 3, 0, 6'h20), 32'hC);
    check("add_result", Result, 32'h0000_00EF);
    read_reg("r3", 3, 32'h0000_00EF);

    // sw / lw
    apply(1'b1, itype(6'h2B, 0, 1, 16'h0008), 32'h10);
    check("sw_addr", Result, 32'h0000_0008);
    read_reg("sw_keeps_r1", 1, 32'h0000_00F0);
    apply(1'b1, itype(6'h23, 0, 4, 16'h0008), 32'h14);
    check("lw_wdata", Wdata, 32'h0000_00F0);
    read_reg("r4", 4, 32'h0000_00F0);
    apply(1'b1, itype(6'h23, 0, 6, 16'h0408), 32'h18);
    check("lw_wrap", Wdata, 32'h0000_00F0);

    // Branches
    apply(1'b1, itype(6'h04, 0, 0, 16'h0003), 32'h0000_0104);
    check("beq_taken", newPC, 32'h0000_0110);
    apply(1'b1, itype(6'h05, 0, 0, 16'h0003), 32'h0000_0104);
    check("bne_not_taken", newPC, 32'h0000_0104);
    apply(1'b1, itype(6'h05, 1, 0, 16'hFFFF), 32'h0000_0104);
    check("bne_taken_back", newPC, 32'h0000_0100);
    apply(1'b1, itype(6'h04, 1, 0, 16'h0003), 32'h0000_0104);
    check("beq_not_taken", newPC, 32'h0000_0104);

    // jal / jr
    apply(1'b1, jtype(6'h03, 26'h40), 32'h0040_0008);
    check("jal_newpc", newPC, 32'h0000_0100);
    check("jal_wdata", Wdata, 32'h0040_0008);
    read_reg("r31", 31, 32'h0040_0008);
    apply(1'b1, rtype(31, 0, 0, 0, 6'h08), 32'h0000_0104);
    check("jr_newpc", newPC, 32'h0040_0008);
    apply(1'b1, jtype(6'h02, 26'h3FF_FFFF), 32'hA000_0000);
    check("j_region", newPC, 32'hAFFF_FFFC);

    // slt, R0 write
    apply(1'b1, rtype(2, 1, 5, 0, 6'h2A), 32'h20);
    check("slt_true", Result, 32'h1);
    apply(1'b1, rtype(1, 2, 6, 0, 6'h2A), 32'h24);
    check("slt_false", Result, 32'h0);
    read_reg("r5", 5, 32'h1);
    apply(1'b1, itype(6'h08, 0, 0, 16'h0005), 32'h28);
    check("addi_r0_result", Result, 32'h5);
    read_reg("r0_zero", 0, 32'h0);

    // Shifts, lui, andi, sub
    apply(1'b1, rtype(0, 1, 7, 4, 6'h00), 32'h2C);
    check("sll", Result, 32'h0000_0F00);
    apply(1'b1, rtype(0, 2, 8, 28, 6'h02), 32'h30);
    check("srl", Result, 32'h0000_000F);
    apply(1'b1, itype(6'h0F, 0, 9, 16'h1234), 32'h34);
    check("lui", Result, 32'h1234_0000);
    apply(1'b1, itype(6'h0C, 2, 10, 16'h8001), 32'h38);
    check("andi_zext", Result, 32'h0000_8001);
    apply(1'b1, rtype(0, 1, 11, 0, 6'h22), 32'h3C);
    check("sub_neg", Result, 32'hFFFF_FF10);
    read_reg("r9", 9, 32'h1234_0000);

    // Unsupported encodings: no write, fall-through PC
    apply(1'b1, itype(6'h3F, 2, 1, 16'h0001), 32'h40);
    check("bad_op_result", Result, 32'h0);
    check("bad_op_newpc", newPC, 32'h40);
    apply(1'b1, rtype(0, 2, 1, 0, 6'h21), 32'h44);
    check("bad_fn_result", Result, 32'h0);
    read_reg("bad_keeps_r1", 1, 32'h0000_00F0);

    // Same-cycle read/write sees old value
    apply(1'b1, rtype(1, 1, 1, 0, 6'h20), 32'h48);
    check("raw_old", Result, 32'h0000_01E0);
    read_reg("raw_new", 1, 32'h0000_01E0);

    // Reset mid-run: registers clear, memory kept, sw suppressed
    apply(1'b0, itype(6'h2B, 0, 2, 16'h0008), 32'h0000_0200);
    check("rst2_newpc", newPC, 32'h0);
    apply(1'b1, itype(6'h23, 0, 4, 16'h0008), 32'h4C);
    check("rst2_mem_kept", Wdata, 32'h0000_00F0);
    read_reg("rst2_r1", 1, 32'h0);
    read_reg("rst2_r31", 31, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
